sms_mem_bridge: RTL and testbench
=================================

Name: sms_mem_bridge

Overview:
- Bridges the 8-bit Z80-side memory bus (byte address, single-cycle request strobe) to one 16-bit toggle-handshake port of the SDRAM controller (req/ack toggle, word address, byte enables).
- Holds a one-word read cache, so the odd/even byte of the last fetched word is served without an SDRAM access.
- Sits directly upstream of the SDRAM controller, one instance per client (CPU ROM/RAM, VDP fetch).

Parameters:
- BASE_WADDR, 24'h000000, word-address offset added to every SDRAM address (region base).
- ADDR_W, 22, width of the CPU byte address.
- CACHE_EN, 1, 1 = one-word read cache enabled; 0 = every read goes to SDRAM.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cpu_req  in  1  one-cycle request strobe
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req
- cpu_addr  in  ADDR_W  byte address; sampled with cpu_req
- cpu_din  in  8  write data
- cpu_dout  out  8  read data; valid when cpu_rdy is high, held until the next read completes
- cpu_rdy  out  1  one-cycle completion pulse (reads and writes)
- cpu_busy  out  1  high from the accepted cpu_req until cpu_rdy, inclusive of the cpu_rdy cycle
- inv  in  1  one-cycle pulse; clears the cache valid bit
- err  out  1  sticky; set when cpu_req arrives while cpu_busy is high; cleared only by reset
- sd_req  out  1  request toggle to the SDRAM port
- sd_ack  in  1  acknowledge toggle from the SDRAM port
- sd_wr  out  1  1 = write
- sd_addr  out  24  word address [24:1]
- sd_din  out  16  write data
- sd_be  out  2  byte enables
- sd_dout  in  16  read data; valid when sd_ack equals sd_req

Behaviour:
- Reset values: sd_req=0, sd_wr=0, sd_addr=0, sd_din=0, sd_be=0, cpu_dout=0, cpu_rdy=0, err=0, cache valid=0, state=SYNC, cpu_busy=1.
- States:
  - SYNC: if sd_ack != sd_req, set sd_req <= sd_ack. Go to IDLE when they are equal. Covers the controller holding a stale ack toggle after reset.
  - IDLE (cpu_busy=0): on cpu_req, latch the request and decide:
    - Read with CACHE_EN=1, valid=1, tag==cpu_addr[ADDR_W-1:1] and no inv in the same cycle: HIT, next cycle DONE.
    - Anything else: drive the sd_* outputs, toggle sd_req, go to WAIT.
  - WAIT: when the registered compare sd_ack==sd_req holds:
    - Read: capture sd_dout into the cache word, set tag, set valid=1.
    - Go to DONE.
  - DONE: pulse cpu_rdy and drive cpu_dout. Go to IDLE. cpu_busy drops the following cycle.
- Address and byte lane rules:
  - sd_addr = BASE_WADDR + cpu_addr[ADDR_W-1:1], modulo 2^24 (wraps silently).
  - Even byte address maps to [7:0], odd to [15:8].
  - Read: cpu_dout = cpu_addr[0] ? word[15:8] : word[7:0]. sd_be=2'b11.
  - Write: sd_din={cpu_din,cpu_din}; sd_be = cpu_addr[0] ? 2'b10 : 2'b01.
- Write policy: write-through, no allocate.
  - A write whose tag equals a valid cache tag also updates that cached byte in the cycle the write is accepted.
  - A write to any other address leaves the cache untouched.
- Latency:
  - Read hit: cpu_rdy 2 cycles after cpu_req.
  - Miss or write: 3 cycles plus the controller latency (req toggle to ack toggle).
- inv:
  - During WAIT on a read, the fill completes but valid is forced to 0.
  - inv has priority over a fill in the same cycle.
- Request while busy: ignored (no state change, no SDRAM access), err set.
- Only one SDRAM transaction is outstanding at a time. sd_* outputs are stable from the sd_req toggle until ack.
- Reset mid-transaction: the transaction is abandoned, no cpu_rdy is issued, and the block re-enters SYNC.

Decomposition:
- Shared package sms_mem_pkg: state encoding (SYNC, IDLE, WAIT, DONE), SDRAM word-address width constant (24), byte-lane helper function (be from address bit 0).
- Sub-module sms_word_cache: tag/valid/data register with lookup, fill, byte-update and invalidate. Keeps the FSM file free of cache muxing.

Test Plan:
- Reset with sd_ack held at 1 -> sd_req becomes 1 within 2 cycles; cpu_busy falls; no SDRAM access issued.
- Write 8'hA5 to 22'h000101 -> sd_addr=24'h000080, sd_be=2'b10, sd_din=16'hA5A5, one sd_req toggle; cpu_rdy after ack.
- Read 22'h000100 (miss, memory word 16'h1234) -> cpu_dout=8'h34. Then read 22'h000101 -> hit, cpu_dout=8'h12, cpu_rdy 2 cycles after cpu_req, no sd_req toggle.
- Cached word 16'h1234 at tag 22'h000100; write 8'h77 to 22'h000101 then read it -> hit returns 8'h77; SDRAM word becomes 16'h7734.
- inv pulse in the same cycle as a read that would hit -> treated as miss, exactly one sd_req toggle.
- cpu_req during WAIT -> err=1 and stays 1; the outstanding transaction completes normally with a single cpu_rdy. BASE_WADDR=24'hFFFFFF with cpu_addr=22'h000002 -> sd_addr=24'h000000.

Source files
------------

// File: rtl/sms_mem_pkg.sv
// ----------------------------------------------------------------------------
// sms_mem_pkg : shared FSM encoding, SDRAM widths and byte-lane helper.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sms_mem_pkg;

  localparam int SD_AW  = 24;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Odd byte addresses live in the upper half of the SDRAM word.
  function automatic logic [1:0] byte_be(input logic addr0);
    return addr0 ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sms_word_cache.sv
// ----------------------------------------------------------------------------
// sms_word_cache : one-word read cache (tag, valid, data) with byte update.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sms_word_cache
  import sms_mem_pkg::*;
#(
  parameter int TAG_W    = 21,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit,
  output logic [WORD_W-1:0] word,
  input  logic              upd_en,
  input  logic              upd_hi,
  input  logic [7:0]        upd_byte,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [WORD_W-1:0] fill_data,
  input  logic              fill_valid,
  input  logic              inv
);

  logic              valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              match;

  assign match = valid_q && (tag_q == lookup_tag);
  assign word  = data_q;

  generate
    if (CACHE_EN) begin : g_hit_on
      assign hit = match;
    end else begin : g_hit_off
      assign hit = 1'b0;
    end
  endgenerate

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d = fill_valid;
      tag_d   = fill_tag;
      data_d  = fill_data;
    end else if (upd_en && match) begin
      if (upd_hi) data_d[15:8] = upd_byte;
      else        data_d[7:0]  = upd_byte;
    end
    // Invalidate wins over any fill or update landing in the same cycle.
    if (inv) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sms_mem_bridge.sv
// ----------------------------------------------------------------------------
// sms_mem_bridge : 8-bit CPU bus to 16-bit toggle-handshake SDRAM port bridge.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sms_mem_bridge
  import sms_mem_pkg::*;
#(
  parameter logic [SD_AW-1:0] BASE_WADDR = 24'h000000,
  parameter int               ADDR_W     = 22,
  parameter bit               CACHE_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_rdy,
  output logic              cpu_busy,
  input  logic              inv,
  output logic              err,
  output logic              sd_req,
  input  logic              sd_ack,
  output logic              sd_wr,
  output logic [SD_AW-1:0]  sd_addr,
  output logic [15:0]       sd_din,
  output logic [1:0]        sd_be,
  input  logic [15:0]       sd_dout
);

  state_e             state_q, state_d;
  logic               sd_req_q, sd_req_d;
  logic               sd_wr_q, sd_wr_d;
  logic [SD_AW-1:0]   sd_addr_q, sd_addr_d;
  logic [15:0]        sd_din_q, sd_din_d;
  logic [1:0]         sd_be_q, sd_be_d;
  logic [7:0]         cpu_dout_q, cpu_dout_d;
  logic               cpu_rdy_q, cpu_rdy_d;
  logic               err_q, err_d;
  logic               ack_match_q, ack_match_d;
  logic               inv_pend_q, inv_pend_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic               cache_hit;
  logic [WORD_W-1:0]  cache_word;
  logic               upd_en, fill_en, fill_valid;

  sms_word_cache #(
    .TAG_W    (ADDR_W - 1),
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .clk        (clk),
    .resetn     (resetn),
    .lookup_tag (cpu_addr[ADDR_W-1:1]),
    .hit        (cache_hit),
    .word       (cache_word),
    .upd_en     (upd_en),
    .upd_hi     (cpu_addr[0]),
    .upd_byte   (cpu_din),
    .fill_en    (fill_en),
    .fill_tag   (addr_q[ADDR_W-1:1]),
    .fill_data  (sd_dout),
    .fill_valid (fill_valid),
    .inv        (inv)
  );

  assign cpu_busy = (state_q != ST_IDLE) | cpu_rdy_q;

  always_comb begin
    state_d    = state_q;
    sd_req_d   = sd_req_q;
    sd_wr_d    = sd_wr_q;
    sd_addr_d  = sd_addr_q;
    sd_din_d   = sd_din_q;
    sd_be_d    = sd_be_q;
    cpu_dout_d = cpu_dout_q;
    cpu_rdy_d  = 1'b0;
    inv_pend_d = inv_pend_q;
    we_d       = we_q;
    addr_d     = addr_q;
    upd_en     = 1'b0;
    fill_en    = 1'b0;
    fill_valid = 1'b0;
    err_d      = err_q | (cpu_req & cpu_busy);

    case (state_q)
      ST_SYNC: begin
        if (sd_ack != sd_req_q) sd_req_d = sd_ack;
        else                    state_d  = ST_IDLE;
      end
      ST_IDLE: begin
        if (cpu_req && !cpu_rdy_q) begin
          we_d   = cpu_we;
          addr_d = cpu_addr;
          if (!cpu_we && cache_hit && !inv) begin
            state_d = ST_DONE;
          end else begin
            upd_en     = cpu_we;
            sd_wr_d    = cpu_we;
            sd_addr_d  = BASE_WADDR + SD_AW'(cpu_addr[ADDR_W-1:1]);
            sd_din_d   = {cpu_din, cpu_din};
            sd_be_d    = cpu_we ? byte_be(cpu_addr[0]) : 2'b11;
            sd_req_d   = ~sd_req_q;
            inv_pend_d = 1'b0;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Any invalidate seen while the fill is in flight makes the fill stale.
        inv_pend_d = inv_pend_q | inv;
        if (ack_match_q) begin
          fill_en    = !we_q;
          fill_valid = !(inv_pend_q | inv);
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        cpu_rdy_d = 1'b1;
        if (!we_q) cpu_dout_d = addr_q[0] ? cache_word[15:8] : cache_word[7:0];
        state_d = ST_IDLE;
      end
      default: state_d = ST_SYNC;
    endcase

    // Compared against the next toggle so the issue cycle never sees a stale match.
    ack_match_d = (sd_ack == sd_req_d);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_SYNC;
      sd_req_q    <= 1'b0;
      sd_wr_q     <= 1'b0;
      sd_addr_q   <= '0;
      sd_din_q    <= '0;
      sd_be_q     <= '0;
      cpu_dout_q  <= '0;
      cpu_rdy_q   <= 1'b0;
      err_q       <= 1'b0;
      ack_match_q <= 1'b0;
      inv_pend_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      sd_req_q    <= sd_req_d;
      sd_wr_q     <= sd_wr_d;
      sd_addr_q   <= sd_addr_d;
      sd_din_q    <= sd_din_d;
      sd_be_q     <= sd_be_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_rdy_q   <= cpu_rdy_d;
      err_q       <= err_d;
      ack_match_q <= ack_match_d;
      inv_pend_q  <= inv_pend_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
    end
  end

  assign sd_req   = sd_req_q;
  assign sd_wr    = sd_wr_q;
  assign sd_addr  = sd_addr_q;
  assign sd_din   = sd_din_q;
  assign sd_be    = sd_be_q;
  assign cpu_dout = cpu_dout_q;
  assign cpu_rdy  = cpu_rdy_q;
  assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sms_mem_bridge.sv
// ----------------------------------------------------------------------------
// tb_sms_mem_bridge : random and directed accesses against a memory/cache model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sms_mem_bridge;

  localparam logic [23:0] BASE = 24'h000000;
  localparam bit          CEN  = 1'b1;

  logic        clk, resetn;
  logic        cpu_req, cpu_we, inv, cpu_rdy, cpu_busy, err;
  logic [21:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        sd_req, sd_ack, sd_wr;
  logic [23:0] sd_addr;
  logic [15:0] sd_din, sd_dout;
  logic [1:0]  sd_be;

  logic        cpu_req2, cpu_we2, inv2, cpu_rdy2, cpu_busy2, err2;
  logic [21:0] cpu_addr2;
  logic [7:0]  cpu_din2, cpu_dout2;
  logic        sd_req2, sd_ack2, sd_wr2;
  logic [23:0] sd_addr2;
  logic [15:0] sd_din2, sd_dout2;
  logic [1:0]  sd_be2;

  sms_mem_bridge #(.BASE_WADDR(BASE), .ADDR_W(22), .CACHE_EN(CEN)) dut (
    .clk(clk), .resetn(resetn), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_rdy(cpu_rdy), .cpu_busy(cpu_busy), .inv(inv), .err(err),
    .sd_req(sd_req), .sd_ack(sd_ack), .sd_wr(sd_wr), .sd_addr(sd_addr),
    .sd_din(sd_din), .sd_be(sd_be), .sd_dout(sd_dout)
  );

  sms_mem_bridge #(.BASE_WADDR(24'hFFFFFF), .ADDR_W(22), .CACHE_EN(1'b0)) dut2 (
    .clk(clk), .resetn(resetn), .cpu_req(cpu_req2), .cpu_we(cpu_we2),
    .cpu_addr(cpu_addr2), .cpu_din(cpu_din2), .cpu_dout(cpu_dout2),
    .cpu_rdy(cpu_rdy2), .cpu_busy(cpu_busy2), .inv(inv2), .err(err2),
    .sd_req(sd_req2), .sd_ack(sd_ack2), .sd_wr(sd_wr2), .sd_addr(sd_addr2),
    .sd_din(sd_din2), .sd_be(sd_be2), .sd_dout(sd_dout2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents: SDRAM model (written by DUT traffic) and reference image.
  logic [15:0] sd_mem  [logic [23:0]];
  logic [15:0] ref_mem [logic [23:0]];

  function automatic logic [15:0] mem_init(input logic [23:0] a);
    return {a[7:0] ^ 8'hC3, a[15:8] ^ a[7:0] ^ 8'h5A};
  endfunction
  function automatic logic [15:0] sd_rd(input logic [23:0] a);
    if (sd_mem.exists(a)) return sd_mem[a];
    return mem_init(a);
  endfunction
  function automatic logic [15:0] ref_rd(input logic [23:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return mem_init(a);
  endfunction

  // Reference cache contents.
  bit          ref_valid = 1'b0;
  logic [20:0] ref_tag   = '0;
  logic [15:0] ref_word  = '0;

  // SDRAM controller model.
  int          serves = 0, last_lat = 0, force_lat = -1, last_n = 0;
  bit          model_en = 1'b0;
  logic [23:0] cap_addr;
  logic [15:0] cap_din;
  logic [1:0]  cap_be;
  logic        cap_wr;

  initial begin
    logic [15:0] w;
    sd_ack  = 1'b1;
    sd_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (model_en && resetn && (sd_req != sd_ack)) begin
        cap_addr = sd_addr; cap_din = sd_din; cap_be = sd_be; cap_wr = sd_wr;
        last_lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        repeat (last_lat) begin @(posedge clk); #1; end
        check("sd_stable", 32'({sd_wr, sd_addr, sd_din, sd_be} == {cap_wr, cap_addr, cap_din, cap_be}), 32'd1);
        if (cap_wr) begin
          w = sd_rd(cap_addr);
          if (cap_be[0]) w[7:0]  = cap_din[7:0];
          if (cap_be[1]) w[15:8] = cap_din[15:8];
          sd_mem[cap_addr] = w;
        end
        sd_dout = sd_rd(cap_addr);
        sd_ack  = sd_req;
        serves++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_idle();
    int g = 0;
    while (cpu_busy !== 1'b0 && g < 60) begin @(posedge clk); #1; g++; end
    check("idle_to", 32'(cpu_busy), 32'd0);
  endtask

  task automatic do_acc(input bit we, input logic [21:0] a, input logic [7:0] d,
                        input bit inv_same, input bit inv_mid);
    logic [23:0] wa;
    logic [15:0] w;
    logic [7:0]  exp_d;
    bit          exp_hit;
    int          s0, n;
    wait_idle();
    wa      = BASE + 24'(a >> 1);
    exp_hit = CEN && !we && ref_valid && (ref_tag == a[21:1]) && !inv_same;
    w       = exp_hit ? ref_word : ref_rd(wa);
    exp_d   = a[0] ? w[15:8] : w[7:0];
    s0      = serves;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d; inv = inv_same;
    @(posedge clk); #1;
    cpu_req = 1'b0; inv = 1'b0; n = 1;
    while (!cpu_rdy && n < 60) begin
      inv = inv_mid && (n == 1);
      @(posedge clk); #1;
      n++;
    end
    inv    = 1'b0;
    last_n = n;
    check("rdy", 32'(cpu_rdy), 32'd1);
    if (exp_hit) begin
      check("hit_lat", n, 2);
      check("hit_acc", serves - s0, 0);
    end else begin
      check("miss_acc", serves - s0, 1);
      check("miss_lat", 32'(n >= 3 && n <= last_lat + 4), 32'd1);
      check("sd_addr", 32'(cap_addr), 32'(wa));
      check("sd_wr", 32'(cap_wr), 32'(we));
      check("sd_be", 32'(cap_be), we ? (a[0] ? 32'd2 : 32'd1) : 32'd3);
      if (we) check("sd_din", 32'(cap_din), 32'({d, d}));
    end
    check("busy_rdy", 32'(cpu_busy), 32'd1);
    if (!we) check("rdata", 32'(cpu_dout), 32'(exp_d));
    @(posedge clk); #1;
    check("rdy_pulse", 32'(cpu_rdy), 32'd0);
    check("busy_drop", 32'(cpu_busy), 32'd0);
    if (inv_same) ref_valid = 1'b0;
    if (we) begin
      w = ref_rd(wa);
      if (a[0]) w[15:8] = d; else w[7:0] = d;
      ref_mem[wa] = w;
      if (ref_valid && ref_tag == a[21:1]) begin
        if (a[0]) ref_word[15:8] = d; else ref_word[7:0] = d;
      end
    end else if (!exp_hit) begin
      ref_valid = 1'b1;
      ref_tag   = a[21:1];
      ref_word  = ref_rd(wa);
    end
    if (inv_mid) ref_valid = 1'b0;
  endtask

  initial begin
    int s, rdys, g;
    logic [15:0] w;
    resetn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0; inv = 1'b0;
    cpu_req2 = 1'b0; cpu_we2 = 1'b0; cpu_addr2 = '0; cpu_din2 = '0; inv2 = 1'b0;
    sd_ack2 = 1'b0; sd_dout2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(sd_req), 32'd0);
    check("rst_busy", 32'(cpu_busy), 32'd1);
    check("rst_rdy", 32'(cpu_rdy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(sd_addr), 32'd0);
    check("rst_be", 32'(sd_be), 32'd0);
    check("rst_dout", 32'(cpu_dout), 32'd0);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sync_req", 32'(sd_req), 32'd1);
    check("sync_busy", 32'(cpu_busy), 32'd0);
    check("sync_wr", 32'(sd_wr), 32'd0);
    model_en = 1'b1;

    // Second instance: base wrap and cache disabled.
    for (int r = 0; r < 2; r++) begin
      g = 0;
      while (cpu_busy2 !== 1'b0 && g < 20) begin @(posedge clk); #1; g++; end
      cpu_req2 = 1'b1; cpu_we2 = 1'b0; cpu_addr2 = 22'h000002;
      @(posedge clk); #1;
      cpu_req2 = 1'b0;
      check("wrap_addr", 32'(sd_addr2), 32'd0);
      check("wrap_toggle", 32'(sd_req2 != sd_ack2), 32'd1);
      check("wrap_be", 32'(sd_be2), 32'd3);
      sd_dout2 = (r == 0) ? 16'hBEEF : 16'h1357;
      sd_ack2  = sd_req2;
      g = 0;
      while (!cpu_rdy2 && g < 20) begin @(posedge clk); #1; g++; end
      check("wrap_rdy", 32'(cpu_rdy2), 32'd1);
      check("wrap_dout", 32'(cpu_dout2), (r == 0) ? 32'hEF : 32'h57);
      @(posedge clk); #1;
    end

    do_acc(1'b1, 22'h000101, 8'hA5, 1'b0, 1'b0);
    check("w_addr", 32'(cap_addr), 32'h80);
    check("w_be", 32'(cap_be), 32'd2);
    check("w_din", 32'(cap_din), 32'hA5A5);

    sd_mem[24'h80]  = 16'h1234;
    ref_mem[24'h80] = 16'h1234;
    do_acc(1'b0, 22'h000100, 8'h00, 1'b0, 1'b0);
    check("miss_dout", 32'(cpu_dout), 32'h34);
    s = serves;
    do_acc(1'b0, 22'h000101, 8'h00, 1'b0, 1'b0);
    check("hit_dout", 32'(cpu_dout), 32'h12);
    check("hit_n", last_n, 2);
    check("hit_noacc", serves - s, 0);

    do_acc(1'b1, 22'h000101, 8'h77, 1'b0, 1'b0);
    do_acc(1'b0, 22'h000101, 8'h00, 1'b0, 1'b0);
    check("wt_dout", 32'(cpu_dout), 32'h77);
    check("wt_mem", 32'(sd_rd(24'h80)), 32'h7734);

    s = serves;
    do_acc(1'b0, 22'h000100, 8'h00, 1'b1, 1'b0);
    check("inv_miss", serves - s, 1);

    for (int i = 0; i < 300; i++) begin
      do_acc(($urandom % 3) == 0, 22'h000100 + 22'($urandom_range(0, 15)), 8'($urandom),
             ($urandom % 8) == 0, ($urandom % 8) == 0);
    end

    foreach (ref_mem[k]) check("mem", 32'(sd_rd(k)), 32'(ref_mem[k]));

    // Request while busy: flagged, ignored, original transaction still completes.
    check("err_clear", 32'(err), 32'd0);
    wait_idle();
    force_lat = 3;
    s = serves; rdys = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h0001F0;
    @(posedge clk); #1;
    cpu_we = 1'b1; cpu_addr = 22'h000200; cpu_din = 8'hEE;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    check("err_set", 32'(err), 32'd1);
    w = ref_rd(24'hF8);
    for (int c = 0; c < 30; c++) begin
      if (cpu_rdy) begin
        rdys++;
        check("err_dout", 32'(cpu_dout), 32'(w[7:0]));
      end
      @(posedge clk); #1;
    end
    check("err_rdys", rdys, 1);
    check("err_acc", serves - s, 1);
    check("err_nowr", 32'(sd_rd(24'h100)), 32'(mem_init(24'h100)));
    check("err_sticky", 32'(err), 32'd1);
    force_lat = -1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
